// File: rtl/proc_mem_arbiter.sv
// Two-requester (imem/dmem) arbiter sharing one in-order 4B memory port.
// Define PROC_MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed dmem priority.

package proc_mem_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

module proc_mem_arbiter
    import proc_mem_arbiter_pkg::*;
#(
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,

    input  mem_req_4B_t                              ireq_msg,
    input  logic                                     ireq_val,
    output logic                                     ireq_rdy,
    output mem_resp_4B_t                             iresp_msg,
    output logic                                     iresp_val,
    input  logic                                     iresp_rdy,

    input  mem_req_4B_t                              dreq_msg,
    input  logic                                     dreq_val,
    output logic                                     dreq_rdy,
    output mem_resp_4B_t                             dresp_msg,
    output logic                                     dresp_val,
    input  logic                                     dresp_rdy,

    output mem_req_4B_t                              memreq_msg,
    output logic                                     memreq_val,
    input  logic                                     memreq_rdy,
    input  mem_resp_4B_t                             memresp_msg,
    input  logic                                     memresp_val,
    output logic                                     memresp_rdy,

    output logic [$clog2(p_max_outstanding+1)-1:0]   num_outstanding
);

    localparam int unsigned DEPTH = p_max_outstanding;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Grant-ID FIFO: one bit per outstanding request (0 = imem, 1 = dmem)
    logic [DEPTH-1:0] ids;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic any_val;
    logic grant;
    logic head_id;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign any_val = ireq_val | dreq_val;

`ifdef PROC_MEM_ARB_ROUND_ROBIN_EN
    logic prio;

    // Preferred requester wins when valid, otherwise the other one
    always_comb begin
        grant = 1'b0;
        if (prio) begin
            grant = dreq_val;
        end else begin
            grant = !ireq_val;
        end
    end

    // Pointer hands preference to the loser after every issued request
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (push) begin
            prio <= ~grant;
        end
    end
`else
    always_comb begin
        grant = dreq_val;
    end
`endif

    // Request side never looks at memresp; full blocks issue even if a pop is pending
    always_comb begin
        memreq_val = !reset && any_val && !full;
        memreq_msg = grant ? dreq_msg : ireq_msg;
        ireq_rdy   = !reset && ireq_val && !grant && memreq_rdy && !full;
        dreq_rdy   = !reset && dreq_val &&  grant && memreq_rdy && !full;
        push       = memreq_val && memreq_rdy;
    end

    assign head_id = ids[head];

    // Response side routes to whichever requester issued the oldest request
    always_comb begin
        iresp_msg   = memresp_msg;
        dresp_msg   = memresp_msg;
        iresp_val   = !reset && memresp_val && !empty && !head_id;
        dresp_val   = !reset && memresp_val && !empty &&  head_id;
        memresp_rdy = !reset && !empty && (head_id ? dresp_rdy : iresp_rdy);
        pop         = memresp_val && memresp_rdy;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ids[tail] <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign num_outstanding = count;

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Randomized and directed bench for proc_mem_arbiter against a queue-based model.
// Follows PROC_MEM_ARB_ROUND_ROBIN_EN for the expected arbitration rule.

module tb_proc_mem_arbiter;
    import proc_mem_arbiter_pkg::*;

    localparam int unsigned P = 4;

    logic         clk = 1'b0;
    logic         reset;
    mem_req_4B_t  ireq_msg;
    logic         ireq_val;
    logic         ireq_rdy;
    mem_resp_4B_t iresp_msg;
    logic         iresp_val;
    logic         iresp_rdy;
    mem_req_4B_t  dreq_msg;
    logic         dreq_val;
    logic         dreq_rdy;
    mem_resp_4B_t dresp_msg;
    logic         dresp_val;
    logic         dresp_rdy;
    mem_req_4B_t  memreq_msg;
    logic         memreq_val;
    logic         memreq_rdy;
    mem_resp_4B_t memresp_msg;
    logic         memresp_val;
    logic         memresp_rdy;
    logic [$clog2(P+1)-1:0] num_outstanding;

    proc_mem_arbiter #(.p_max_outstanding(P)) dut (
        .clk             (clk),
        .reset           (reset),
        .ireq_msg        (ireq_msg),
        .ireq_val        (ireq_val),
        .ireq_rdy        (ireq_rdy),
        .iresp_msg       (iresp_msg),
        .iresp_val       (iresp_val),
        .iresp_rdy       (iresp_rdy),
        .dreq_msg        (dreq_msg),
        .dreq_val        (dreq_val),
        .dreq_rdy        (dreq_rdy),
        .dresp_msg       (dresp_msg),
        .dresp_val       (dresp_val),
        .dresp_rdy       (dresp_rdy),
        .memreq_msg      (memreq_msg),
        .memreq_val      (memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memresp_msg     (memresp_msg),
        .memresp_val     (memresp_val),
        .memresp_rdy     (memresp_rdy),
        .num_outstanding (num_outstanding)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q[$];          // requester IDs of issued, unanswered requests, oldest first
    int pref = 0;      // requester preferred on a tie (round-robin only)

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_msgs();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        ireq_msg = r[76:0];
        r = {$urandom(), $urandom(), $urandom()};
        dreq_msg = r[76:0];
        r = {$urandom(), $urandom(), $urandom()};
        memresp_msg = r[46:0];
    endtask

    // Apply one cycle of inputs, check all outputs against the model, then clock it
    task automatic step(input logic rst, input logic iv, input logic dv, input logic mrdy,
                        input logic mv, input logic irdy, input logic drdy);
        int   cnt;
        int   win;
        int   head;
        logic is_full;
        logic exp_mv, exp_ir, exp_dr, exp_iv, exp_dv, exp_mrr;
        reset       = rst;
        ireq_val    = iv;
        dreq_val    = dv;
        memreq_rdy  = mrdy;
        memresp_val = mv;
        iresp_rdy   = irdy;
        dresp_rdy   = drdy;
        #1;
        cnt     = q.size();
        is_full = (cnt == P);
        if (!iv && !dv) win = -1;
        else if (iv && dv) begin
`ifdef PROC_MEM_ARB_ROUND_ROBIN_EN
            win = pref;
`else
            win = 1;
`endif
        end else win = dv ? 1 : 0;
        head    = (cnt == 0) ? -1 : q[0];
        exp_mv  = !rst && (win >= 0) && !is_full;
        exp_ir  = !rst && (win == 0) && mrdy && !is_full;
        exp_dr  = !rst && (win == 1) && mrdy && !is_full;
        exp_iv  = !rst && mv && (head == 0);
        exp_dv  = !rst && mv && (head == 1);
        exp_mrr = !rst && ((head == 0) ? irdy : (head == 1) ? drdy : 1'b0);

        chk("num_outstanding", 128'(num_outstanding), 128'(cnt));
        chk("memreq_val", 128'(memreq_val), 128'(exp_mv));
        chk("ireq_rdy", 128'(ireq_rdy), 128'(exp_ir));
        chk("dreq_rdy", 128'(dreq_rdy), 128'(exp_dr));
        chk("memresp_rdy", 128'(memresp_rdy), 128'(exp_mrr));
        chk("iresp_val", 128'(iresp_val), 128'(exp_iv));
        chk("dresp_val", 128'(dresp_val), 128'(exp_dv));
        chk("iresp_msg", 128'(iresp_msg), 128'(memresp_msg));
        chk("dresp_msg", 128'(dresp_msg), 128'(memresp_msg));
        if (exp_mv)
            chk("memreq_msg", 128'(memreq_msg), (win == 1) ? 128'(dreq_msg) : 128'(ireq_msg));

        @(posedge clk);
        if (rst) begin
            q.delete();
            pref = 0;
        end else begin
            if (mv && exp_mrr) void'(q.pop_front());
            if (exp_mv && mrdy) begin
                q.push_back(win);
                pref = 1 - win;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        ireq_val = 1'b0; dreq_val = 1'b0; memreq_rdy = 1'b0;
        memresp_val = 1'b0; iresp_rdy = 1'b0; dresp_rdy = 1'b0;
        rand_msgs();
        @(negedge clk);

        // Reset, then three idle cycles
        step(1, 0, 0, 1, 0, 1, 1);
        step(1, 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1, 1);

        // Single imem read of 0x200 returning 0xDEADBEEF
        rand_msgs();
        ireq_msg.addr = 32'h0000_0200;
        step(0, 1, 0, 1, 0, 1, 1);
        chk("single_cnt_after_issue", 128'(num_outstanding), 128'd1);
        memresp_msg.data = 32'hDEADBEEF;
        step(0, 0, 0, 1, 1, 1, 1);
        chk("single_iresp_data", 128'(iresp_msg.data), 128'h0DEADBEEF);
        chk("single_cnt_after_resp", 128'(num_outstanding), 128'd0);

        // Both requesters valid until full; the 5th attempt coincides with a response
        for (int i = 0; i < 4; i++) begin
            rand_msgs();
            step(0, 1, 1, 1, 0, 1, 1);
        end
        chk("full_cnt", 128'(num_outstanding), 128'd4);
        rand_msgs();
        step(0, 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            rand_msgs();
            step(0, 0, 0, 1, 1, 1, 1);
        end
        chk("drained_cnt", 128'(num_outstanding), 128'd0);

        // Issue i, d, i; stall imem response for two cycles; then drain in order
        rand_msgs(); step(0, 1, 0, 1, 0, 1, 1);
        rand_msgs(); step(0, 0, 1, 1, 0, 1, 1);
        rand_msgs(); step(0, 1, 0, 1, 0, 1, 1);
        rand_msgs(); step(0, 0, 0, 1, 1, 0, 1);
        rand_msgs(); step(0, 0, 0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            rand_msgs();
            step(0, 0, 0, 1, 1, 1, 1);
        end

        // Reset with three outstanding; a following response must not be taken
        for (int i = 0; i < 3; i++) begin
            rand_msgs();
            step(0, (i != 1), (i == 1), 1, 0, 1, 1);
        end
        chk("pre_reset_cnt", 128'(num_outstanding), 128'd3);
        step(1, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rand_msgs();
            step(($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
